// File: rtl/l0_skew_feeder_pkg.sv
// Shared definitions for the L0 skew feeder: default geometry, the array
// instruction encoding and the skew-stage record.
package l0_skew_feeder_pkg;

    localparam int BW_DEFAULT    = 4;
    localparam int ROW_DEFAULT   = 8;
    localparam int DEPTH_DEFAULT = 16;

    localparam int INST_W = 3;

    // Array instruction bits: bit2 output-stationary select,
    // bit1 execute / pass psum, bit0 load / accumulate.
    localparam logic [INST_W-1:0] INST_IDLE     = 3'b000;
    localparam logic [INST_W-1:0] INST_LOAD_ACC = 3'b001;
    localparam logic [INST_W-1:0] INST_EXEC     = 3'b010;
    localparam logic [INST_W-1:0] INST_OS_SEL   = 3'b100;

    // One slot of the skew shift register: a pending pop and its instruction.
    typedef struct packed {
        logic              valid;
        logic [INST_W-1:0] inst;
    } skew_stage_t;

    localparam skew_stage_t SKEW_IDLE = '{valid: 1'b0, inst: INST_IDLE};

endpackage

// File: rtl/l0_lane_fifo.sv
// Single-lane FIFO with wrap-bit pointers. Push/pop are assumed already
// qualified by the caller against full/empty.
module l0_lane_fifo
    import l0_skew_feeder_pkg::*;
#(
    parameter int bw    = BW_DEFAULT,
    parameter int depth = DEPTH_DEFAULT
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          push,
    input  logic          pop,
    input  logic [bw-1:0] wdata,
    output logic [bw-1:0] rdata,
    output logic          full,
    output logic          empty
);

    localparam int AW = $clog2(depth);
    localparam logic [AW:0] PTR_INC = 1;

    logic [AW:0]   wr_ptr;
    logic [AW:0]   rd_ptr;
    logic [bw-1:0] mem [depth];

    assign full  = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
    assign empty = (wr_ptr == rd_ptr);
    assign rdata = mem[rd_ptr[AW-1:0]];

    // Pointer advance; push and pop in the same cycle both take effect.
    always_ff @(posedge clk or negedge reset) begin
        // NOTE: sequential state uses <= so every register samples pre-edge values.
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_INC;
            if (pop)  rd_ptr <= rd_ptr + PTR_INC;
        end
    end

    // Storage write.
    always_ff @(posedge clk) begin
        // NOTE: storage is not reset; the pointers alone define which entries are live.
        if (push) mem[wr_ptr[AW-1:0]] <= wdata;
    end

endmodule

// File: rtl/l0_skew_feeder.sv
// Feeds a systolic array's rows from per-row FIFOs. A read wave pops lane 0
// immediately and lane k k cycles later, carrying the array instruction along.
module l0_skew_feeder
    import l0_skew_feeder_pkg::*;
#(
    parameter int bw    = BW_DEFAULT,
    parameter int row   = ROW_DEFAULT,
    parameter int depth = DEPTH_DEFAULT
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [row*bw-1:0]     in,
    input  logic                  wr,
    input  logic                  rd,
    input  logic [INST_W-1:0]     inst_in,
    output logic [row*bw-1:0]     out,
    output logic [row*INST_W-1:0] inst_out,
    output logic [row-1:0]        o_valid,
    output logic                  full,
    output logic                  empty
);

    logic [row-1:0]    lane_full;
    logic [row-1:0]    lane_empty;
    logic [row-1:0]    lane_pop;
    logic [bw-1:0]     lane_head [row];
    logic              push;

    // pend[k] is the pop request seen by lane k this cycle.
    skew_stage_t       pend   [row];
    skew_stage_t       skew_q [row-1];

    logic [bw-1:0]     out_q  [row];
    logic [INST_W-1:0] inst_q [row];

    // The last lane drains last, so it bounds writes; lane 0 pops first, so it bounds reads.
    assign full  = lane_full[row-1];
    assign empty = lane_empty[0];
    assign push  = wr & ~full;

    // Per-lane pop requests: lane 0 straight from rd, others from the skew chain.
    always_comb begin
        // NOTE: every output gets a default first so no path leaves a latch behind.
        pend[0]  = SKEW_IDLE;
        lane_pop = '0;
        if (rd && !empty) pend[0] = '{valid: 1'b1, inst: inst_in};
        for (int k = 1; k < row; k++) pend[k] = skew_q[k-1];
        for (int k = 0; k < row; k++) lane_pop[k] = pend[k].valid & ~lane_empty[k];
    end

    // Skew shift register: stage k carries the request for lane k+1.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int k = 0; k < row-1; k++) skew_q[k] <= SKEW_IDLE;
        end else begin
            for (int k = 0; k < row-1; k++) skew_q[k] <= pend[k];
        end
    end

    // Registered lane outputs: data holds between pops, valid/inst are one-shot.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            o_valid <= '0;
            for (int k = 0; k < row; k++) begin
                out_q[k]  <= '0;
                inst_q[k] <= INST_IDLE;
            end
        end else begin
            for (int k = 0; k < row; k++) begin
                o_valid[k] <= lane_pop[k];
                inst_q[k]  <= lane_pop[k] ? pend[k].inst : INST_IDLE;
                if (lane_pop[k]) out_q[k] <= lane_head[k];
            end
        end
    end

    for (genvar k = 0; k < row; k++) begin : g_lane
        l0_lane_fifo #(
            .bw    (bw),
            .depth (depth)
        ) u_fifo (
            .clk   (clk),
            .reset (reset),
            .push  (push),
            .pop   (lane_pop[k]),
            .wdata (in[k*bw +: bw]),
            .rdata (lane_head[k]),
            .full  (lane_full[k]),
            .empty (lane_empty[k])
        );

        assign out[k*bw +: bw]             = out_q[k];
        assign inst_out[k*INST_W +: INST_W] = inst_q[k];

        // The last lane always holds the most entries, so no lane is full without it.
        a_full_order: assert property (@(posedge clk) disable iff (!reset)
            lane_full[k] |-> full);

        if (k > 0) begin : g_chk
            // A skewed pop must always find data in its lane.
            a_skew_data: assert property (@(posedge clk) disable iff (!reset)
                !(pend[k].valid && lane_empty[k]));
        end
    end

endmodule

// File: tb/tb_l0_skew_feeder.sv
// Self-checking bench for l0_skew_feeder: a reference queue model with a
// per-lane scoreboard, a constant vector table and hand-written sequences.
module tb_l0_skew_feeder;
    import l0_skew_feeder_pkg::*;

    localparam int BW    = 4;
    localparam int ROW   = 8;
    localparam int DEPTH = 16;
    localparam int W     = ROW * BW;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic [W-1:0]      in = '0;
    logic              wr = 1'b0;
    logic              rd = 1'b0;
    logic [2:0]        inst_in = '0;
    logic [W-1:0]      out;
    logic [ROW*3-1:0]  inst_out;
    logic [ROW-1:0]    o_valid;
    logic              full;
    logic              empty;

    always #5 clk = ~clk;

    l0_skew_feeder #(.bw(BW), .row(ROW), .depth(DEPTH)) dut (
        .clk      (clk),
        .reset    (reset),
        .in       (in),
        .wr       (wr),
        .rd       (rd),
        .inst_in  (inst_in),
        .out      (out),
        .inst_out (inst_out),
        .o_valid  (o_valid),
        .full     (full),
        .empty    (empty)
    );

    typedef struct {
        logic [BW-1:0] data;
        logic [2:0]    inst;
        int            due;
    } pop_t;

    typedef struct {
        logic           wr;
        logic [W-1:0]   data;
        logic           rd;
        logic [2:0]     inst;
        logic [ROW-1:0] exp_valid;
        logic           exp_empty;
    } vec_t;

    int           n_checks = 0;
    int           n_fail   = 0;
    int           cyc      = 0;
    int           occ_last = 0;
    logic [W-1:0] wq [$];
    pop_t         sb [ROW][$];
    logic [W-1:0] exp_out = '0;
    vec_t         tbl [10];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Drive one cycle of inputs, advance the model across the edge, compare all outputs.
    task automatic step(input logic w, input logic [W-1:0] d, input logic r, input logic [2:0] ins);
        logic           acc_w;
        logic           acc_r;
        logic [W-1:0]   v;
        logic [ROW-1:0] ev;
        logic [ROW*3-1:0] ei;
        pop_t           p;
        wr = w; in = d; rd = r; inst_in = ins;
        acc_w = w && (occ_last != DEPTH);
        acc_r = r && (wq.size() != 0);
        @(posedge clk);
        cyc++;
        if (acc_r) begin
            v = wq.pop_front();
            for (int k = 0; k < ROW; k++) begin
                p.data = v[k*BW +: BW];
                p.inst = ins;
                p.due  = cyc + k;
                sb[k].push_back(p);
            end
        end
        if (acc_w) begin
            wq.push_back(d);
            occ_last++;
        end
        ev = '0;
        ei = '0;
        for (int k = 0; k < ROW; k++) begin
            if (sb[k].size() != 0 && sb[k][0].due == cyc) begin
                p = sb[k].pop_front();
                ev[k] = 1'b1;
                ei[k*3 +: 3] = p.inst;
                exp_out[k*BW +: BW] = p.data;
                if (k == ROW-1) occ_last--;
            end
        end
        #1;
        check("o_valid",  o_valid,  ev);
        check("out",      out,      exp_out);
        check("inst_out", inst_out, ei);
        check("full",     full,     occ_last == DEPTH);
        check("empty",    empty,    wq.size() == 0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, '0, 1'b0, INST_IDLE);
    endtask

    // Assert reset asynchronously, check cleared outputs, clear the model, release.
    task automatic apply_reset();
        reset = 1'b0;
        wr = 1'b0; rd = 1'b0;
        #1;
        check("rst_out",      out,      0);
        check("rst_inst_out", inst_out, 0);
        check("rst_o_valid",  o_valid,  0);
        check("rst_full",     full,     0);
        check("rst_empty",    empty,    1);
        wq.delete();
        for (int k = 0; k < ROW; k++) sb[k].delete();
        occ_last = 0;
        exp_out  = '0;
        @(negedge clk);
        reset = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        int           v7;
        logic [W-1:0] d;

        // Single write then single wave with inst 010.
        tbl[0] = '{1'b1, 32'h7654_3210, 1'b0, 3'b000, 8'h00, 1'b0};
        tbl[1] = '{1'b0, 32'h0,         1'b1, 3'b010, 8'h01, 1'b1};
        tbl[2] = '{1'b0, 32'h0,         1'b0, 3'b000, 8'h02, 1'b1};
        tbl[3] = '{1'b0, 32'h0,         1'b0, 3'b000, 8'h04, 1'b1};
        tbl[4] = '{1'b0, 32'h0,         1'b0, 3'b000, 8'h08, 1'b1};
        tbl[5] = '{1'b0, 32'h0,         1'b0, 3'b000, 8'h10, 1'b1};
        tbl[6] = '{1'b0, 32'h0,         1'b0, 3'b000, 8'h20, 1'b1};
        tbl[7] = '{1'b0, 32'h0,         1'b0, 3'b000, 8'h40, 1'b1};
        tbl[8] = '{1'b0, 32'h0,         1'b0, 3'b000, 8'h80, 1'b1};
        tbl[9] = '{1'b0, 32'h0,         1'b0, 3'b000, 8'h00, 1'b1};

        repeat (2) @(posedge clk);
        apply_reset();

        // Read with nothing stored: nothing may appear for row+1 cycles.
        step(1'b0, '0, 1'b1, 3'b111);
        idle(ROW);

        // Table-driven single wave.
        for (int i = 0; i < 10; i++) begin
            step(tbl[i].wr, tbl[i].data, tbl[i].rd, tbl[i].inst);
            check("tbl_valid", o_valid, tbl[i].exp_valid);
            check("tbl_empty", empty,   tbl[i].exp_empty);
            for (int k = 0; k < ROW; k++) begin
                if (tbl[i].exp_valid[k]) begin
                    check("tbl_lane_data", out[k*BW +: BW], BW'(k));
                    check("tbl_lane_inst", inst_out[k*3 +: 3], 3'b010);
                end
            end
        end

        // Streaming: one priming write, then wr and rd together for 40 cycles.
        step(1'b1, W'($urandom), 1'b0, INST_IDLE);
        v7 = 0;
        for (int i = 0; i < 40; i++) begin
            step(1'b1, W'($urandom), 1'b1, 3'(i));
            v7 += int'(o_valid[ROW-1]);
        end
        for (int i = 0; i < ROW; i++) begin
            step(1'b0, '0, 1'b1, INST_EXEC);
            v7 += int'(o_valid[ROW-1]);
        end
        check("stream_lane7_pops", v7, 41);
        idle(ROW);

        // Fill to full, then one write that must be dropped, then drain in order.
        for (int i = 0; i < DEPTH; i++) begin
            d = W'($urandom);
            step(1'b1, d, 1'b0, INST_IDLE);
        end
        check("full_after_fill", full, 1);
        step(1'b1, 32'hDEAD_BEEF, 1'b0, INST_IDLE);
        check("full_after_drop", full, 1);
        for (int i = 0; i < DEPTH; i++) step(1'b0, '0, 1'b1, INST_LOAD_ACC);
        idle(ROW);
        check("empty_after_drain", empty, 1);
        check("not_full_after_drain", full, 0);

        // Reset three cycles into a wave: lanes 3..7 must never pop.
        step(1'b1, 32'hFEDC_BA98, 1'b0, INST_IDLE);
        step(1'b0, '0, 1'b1, INST_OS_SEL);
        idle(2);
        apply_reset();
        idle(ROW + 1);

        // First edge after release accepts a write.
        step(1'b1, 32'h1357_9BDF, 1'b0, INST_IDLE);
        check("write_after_reset", empty, 0);
        step(1'b0, '0, 1'b1, INST_EXEC);
        idle(ROW);

        for (int k = 0; k < ROW; k++) check("sb_drained", sb[k].size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
